display_scanner: RTL and testbench
==================================

DISPLAY_SCANNER -- requirements
Module: display_scanner

Interface
REQ-001 The block SHALL have these parameters:
- NUM_DIGITS, default 6, number of multiplexed digits, legal range 2..16.
- DIGIT_W, default 4, bits per digit code.
- DWELL, default 1000, clk cycles each digit is lit, minimum 1.
- GUARD, default 2, all-off cycles before each digit to prevent ghosting, minimum 0.
REQ-002 The block SHALL have these ports (clock and reset first):
- clk  in  1  sole clock.
- rst  in  1  synchronous, active-high reset.
- en  in  1  scan enable.
- number_sig  in  NUM_DIGITS*DIGIT_W  digit codes; index 0 is the most significant slice [NUM_DIGITS*DIGIT_W-1 -: DIGIT_W].
- lz_suppress  in  1  leading-zero blanking enable.
- blank_mask  in  NUM_DIGITS  bit i forces digit index i dark.
- dp_mask  in  NUM_DIGITS  bit i lights the decimal point with digit i.
- number_data  out  DIGIT_W  code of the currently lit digit.
- digit_sel  out  NUM_DIGITS  one-hot active-high digit enable.
- dp  out  1  decimal point for the current digit.
- digit_idx  out  $clog2(NUM_DIGITS)  current digit index.
- frame_start  out  1  one-cycle pulse at the start of each frame.
REQ-003 The block SHALL have one clock domain; rst SHALL be sampled only on the rising edge of clk.
REQ-004 All outputs SHALL be registered.

Function
REQ-005 The FSM SHALL have three states: IDLE, GUARD and SHOW.
REQ-006 In IDLE, number_data, digit_sel, dp and digit_idx SHALL be 0, and frame_start SHALL be 0.
REQ-007 In IDLE with en=1, the next cycle SHALL:
- enter GUARD with digit_idx=0 (or SHOW if GUARD=0);
- pulse frame_start;
- snapshot number_sig, blank_mask, dp_mask and lz_suppress.
REQ-008 GUARD SHALL last exactly GUARD cycles with digit_sel=0, number_data=0 and dp=0; digit_idx SHALL already show the upcoming digit.
REQ-009 SHOW SHALL last exactly DWELL cycles and drive:
- number_data = snapshot slice for digit_idx;
- digit_sel = one-hot(digit_idx) unless that digit is blanked;
- dp = snapshot dp_mask[digit_idx] unless that digit is blanked.
REQ-010 At the end of SHOW, if digit_idx<NUM_DIGITS-1, the block SHALL increment digit_idx and go to GUARD (or SHOW if GUARD=0).
REQ-011 At the end of SHOW for the last digit, digit_idx SHALL wrap to 0. In the same transition the block SHALL pulse frame_start and take a new snapshot.
REQ-012 The frame period SHALL be exactly NUM_DIGITS*(GUARD+DWELL) cycles. The snapshot taken at frame start SHALL be the only source of data for the whole frame; input changes mid-frame SHALL have no effect until the next frame_start.
REQ-013 Digit i SHALL be blanked if either condition holds:
- snapshot blank_mask[i]=1;
- lz_suppress=1, i<NUM_DIGITS-1, and digits 0..i in the snapshot are all zero.
The last digit SHALL never be blanked by leading-zero suppression.
REQ-014 A blanked digit SHALL still occupy its GUARD+DWELL slot with digit_sel=0 and dp=0; number_data SHALL still carry its code.
REQ-015 If en=0 is sampled in any state, the next cycle SHALL be IDLE. The frame is aborted, digit_idx=0, and no frame_start is issued.
REQ-016 On re-enable, scanning SHALL always restart at digit 0 per REQ-007.
REQ-017 Dwell/guard counters SHALL be sized $clog2(max(DWELL,GUARD)+1) bits and SHALL never overflow.
REQ-018 digit_sel SHALL never have more than one bit set in any cycle.

Reset
REQ-019 With rst=1 on a rising edge, the next cycle SHALL be IDLE with every output 0, digit_idx=0, counters 0 and the snapshot cleared.
REQ-020 rst SHALL take priority over en and over any in-progress state.
REQ-021 Reset asserted mid-SHOW SHALL drop digit_sel to 0 on the next cycle.

Verification
(All scenarios use NUM_DIGITS=6, DIGIT_W=4, DWELL=3, GUARD=1.)
REQ-022 Reset: hold rst=1 for 2 cycles with en=1 -> all outputs 0; after release, frame_start pulses one cycle later.
REQ-023 Basic scan: number_sig=24'h123456, en=1, masks 0 -> per 4-cycle slot, 1 cycle digit_sel=0 then 3 cycles with:
- number_data 1,2,3,4,5,6;
- digit_sel 000001,000010,...,100000.
frame_start pulses every 24 cycles.
REQ-024 Leading zeros: lz_suppress=1.
- number_sig=24'h000045 -> digit_sel=0 in slots 0-3; slot 4 shows 4 with 010000; slot 5 shows 5 with 100000.
- number_sig=24'h000000 -> only slot 5 lights, showing 0.
- number_sig=24'h100005 -> all six slots light.
REQ-025 Coherence and masks: change number_sig from 24'h111111 to 24'h999999 during slot 2 -> slots 3-5 still show 1; the next frame shows 9. With blank_mask=6'b000100 and dp_mask=6'b001000 -> slot 2 is dark, and slot 3 has dp=1.
REQ-026 Enable/reset abort: drop en during slot 3 SHOW -> next cycle all outputs 0. Re-raise en -> frame_start pulses and scanning restarts at digit 0. Assert rst mid-SHOW -> same restart behaviour.

Source files
------------

// File: rtl/display_scanner.sv
// rtl/display_scanner.sv - multiplexed digit scanner with guard gaps, leading-zero blanking and per-frame snapshot
// Each frame latches its inputs once, then walks the digits through guard (all dark) and show slots.
module display_scanner #(
  parameter int NUM_DIGITS = 6,
  parameter int DIGIT_W    = 4,
  parameter int DWELL      = 1000,
  parameter int GUARD      = 2
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            en,
  input  logic [NUM_DIGITS*DIGIT_W-1:0]   number_sig,
  input  logic                            lz_suppress,
  input  logic [NUM_DIGITS-1:0]           blank_mask,
  input  logic [NUM_DIGITS-1:0]           dp_mask,
  output logic [DIGIT_W-1:0]              number_data,
  output logic [NUM_DIGITS-1:0]           digit_sel,
  output logic                            dp,
  output logic [$clog2(NUM_DIGITS)-1:0]   digit_idx,
  output logic                            frame_start
);

  localparam int IW   = $clog2(NUM_DIGITS);
  localparam int MAXC = (DWELL > GUARD) ? DWELL : GUARD;
  localparam int CW   = $clog2(MAXC + 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_GUARD = 2'd1;
  localparam logic [1:0] S_SHOW  = 2'd2;
  // With no guard gap every digit slot starts directly in SHOW.
  localparam logic [1:0] S_FIRST = (GUARD == 0) ? S_SHOW : S_GUARD;

  localparam logic [CW-1:0] GUARD_LAST = CW'(GUARD - 1);
  localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);

  logic [1:0]                       state_q, state_d;
  logic [CW-1:0]                    cnt_q, cnt_d;
  logic [IW-1:0]                    idx_q, idx_d;
  logic [NUM_DIGITS*DIGIT_W-1:0]    snap_num_q, snap_num_d;
  logic [NUM_DIGITS-1:0]            snap_blank_q, snap_blank_d;
  logic [NUM_DIGITS-1:0]            snap_dp_q, snap_dp_d;
  logic                             snap_lz_q, snap_lz_d;
  logic                             start_q, start_d;
  logic [DIGIT_W-1:0]               data_q, data_d;
  logic [NUM_DIGITS-1:0]            sel_q, sel_d;
  logic                             dp_q, dp_d;

  logic [DIGIT_W-1:0]               digits [NUM_DIGITS];
  logic [NUM_DIGITS-1:0]            blank_d;
  logic [NUM_DIGITS-1:0]            onehot_d;
  logic                             zero_run;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    idx_d        = idx_q;
    snap_num_d   = snap_num_q;
    snap_blank_d = snap_blank_q;
    snap_dp_d    = snap_dp_q;
    snap_lz_d    = snap_lz_q;
    start_d      = 1'b0;

    if (!en) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      idx_d   = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          state_d = S_FIRST;
          cnt_d   = '0;
          idx_d   = '0;
          start_d = 1'b1;
        end
        S_GUARD: begin
          if (cnt_q == GUARD_LAST) begin
            state_d = S_SHOW;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        S_SHOW: begin
          if (cnt_q == DWELL_LAST) begin
            state_d = S_FIRST;
            cnt_d   = '0;
            if (idx_q == IDX_LAST) begin
              idx_d   = '0;
              start_d = 1'b1;
            end else begin
              idx_d = idx_q + 1'b1;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: begin
          state_d = S_IDLE;
          cnt_d   = '0;
          idx_d   = '0;
        end
      endcase
    end

    // A frame only ever sees the inputs captured on its own frame_start edge.
    if (start_d) begin
      snap_num_d   = number_sig;
      snap_blank_d = blank_mask;
      snap_dp_d    = dp_mask;
      snap_lz_d    = lz_suppress;
    end
  end

  // Outputs are derived from next-state values so they register in step with the FSM.
  always_comb begin
    for (int i = 0; i < NUM_DIGITS; i++) begin
      digits[i] = snap_num_d[(NUM_DIGITS-1-i)*DIGIT_W +: DIGIT_W];
    end

    zero_run = 1'b1;
    blank_d  = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      zero_run   = zero_run & (digits[i] == '0);
      blank_d[i] = snap_blank_d[i] | (snap_lz_d & zero_run & (i < NUM_DIGITS - 1));
    end

    onehot_d = {{(NUM_DIGITS-1){1'b0}}, 1'b1} << idx_d;

    data_d = '0;
    sel_d  = '0;
    dp_d   = 1'b0;
    if (state_d == S_SHOW) begin
      data_d = digits[idx_d];
      if (!blank_d[idx_d]) begin
        sel_d = onehot_d;
        dp_d  = snap_dp_d[idx_d];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      idx_q        <= '0;
      snap_num_q   <= '0;
      snap_blank_q <= '0;
      snap_dp_q    <= '0;
      snap_lz_q    <= 1'b0;
      start_q      <= 1'b0;
      data_q       <= '0;
      sel_q        <= '0;
      dp_q         <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      snap_num_q   <= snap_num_d;
      snap_blank_q <= snap_blank_d;
      snap_dp_q    <= snap_dp_d;
      snap_lz_q    <= snap_lz_d;
      start_q      <= start_d;
      data_q       <= data_d;
      sel_q        <= sel_d;
      dp_q         <= dp_d;
    end
  end

  assign number_data = data_q;
  assign digit_sel   = sel_q;
  assign dp          = dp_q;
  assign digit_idx   = idx_q;
  assign frame_start = start_q;

endmodule

// File: tb/tb_display_scanner.sv
// tb/tb_display_scanner.sv - scoreboard bench for display_scanner (6 digits, DWELL=3, GUARD=1)
module tb_display_scanner;

  typedef struct packed {
    logic       fs;
    logic [2:0] idx;
    logic [5:0] sel;
    logic [3:0] data;
    logic       dp;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        en;
  logic [23:0] number_sig;
  logic        lz_suppress;
  logic [5:0]  blank_mask;
  logic [5:0]  dp_mask;
  logic [3:0]  number_data;
  logic [5:0]  digit_sel;
  logic        dp;
  logic [2:0]  digit_idx;
  logic        frame_start;

  int   n_checks;
  int   n_errors;
  exp_t exp_q[$];

  display_scanner #(.NUM_DIGITS(6), .DIGIT_W(4), .DWELL(3), .GUARD(1)) dut (
    .clk(clk), .rst(rst), .en(en), .number_sig(number_sig), .lz_suppress(lz_suppress),
    .blank_mask(blank_mask), .dp_mask(dp_mask), .number_data(number_data),
    .digit_sel(digit_sel), .dp(dp), .digit_idx(digit_idx), .frame_start(frame_start)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic exp_t observe();
    return {frame_start, digit_idx, digit_sel, number_data, dp};
  endfunction

  // Drives the frame inputs and queues the 24 cycles the next frame must produce.
  task automatic push_frame(input logic [23:0] num, input logic lz, input logic [5:0] bm,
                            input logic [5:0] dm);
    exp_t       e;
    logic [3:0] dig;
    logic       zrun;
    logic       blank;
    en          = 1'b1;
    number_sig  = num;
    lz_suppress = lz;
    blank_mask  = bm;
    dp_mask     = dm;
    zrun = 1'b1;
    for (int d = 0; d < 6; d++) begin
      dig   = num[23-4*d -: 4];
      zrun  = zrun & (dig == 4'h0);
      blank = bm[d] | (lz & zrun & (d < 5));
      e = '{fs: (d == 0), idx: 3'(d), sel: 6'd0, data: 4'h0, dp: 1'b0};
      exp_q.push_back(e);
      for (int k = 0; k < 3; k++) begin
        e.fs   = 1'b0;
        e.data = dig;
        e.sel  = blank ? 6'd0 : (6'd1 << d);
        e.dp   = blank ? 1'b0 : dm[d];
        exp_q.push_back(e);
      end
    end
  endtask

  task automatic test_reset();
    exp_t got;
    rst = 1'b1; en = 1'b1; number_sig = 24'h123456;
    lz_suppress = 1'b0; blank_mask = 6'h3f; dp_mask = 6'h3f;
    for (int c = 0; c < 2; c++) begin
      @(posedge clk); #1;
      got = observe();
      n_checks++;
      if (got !== '0) begin
        n_errors++;
        $display("FAIL reset_outputs cyc %0d: got %h, expected 0", c, got);
      end
    end
    rst = 1'b0;
  endtask

  task automatic test_basic_scan();
    exp_t got, e;
    push_frame(24'h123456, 1'b0, 6'd0, 6'd0);
    push_frame(24'h123456, 1'b0, 6'd0, 6'd0);
    for (int c = 0; c < 48; c++) begin
      @(posedge clk); #1;
      got = observe();
      e = exp_q.pop_front();
      n_checks++;
      if (got !== e) begin
        n_errors++;
        $display("FAIL basic_scan cyc %0d: got fs=%b idx=%0d sel=%b data=%h dp=%b, expected fs=%b idx=%0d sel=%b data=%h dp=%b",
                 c, got.fs, got.idx, got.sel, got.data, got.dp, e.fs, e.idx, e.sel, e.data, e.dp);
      end
    end
  endtask

  task automatic test_leading_zeros();
    exp_t        got, e;
    logic [23:0] nums [3];
    nums = '{24'h000045, 24'h000000, 24'h100005};
    for (int f = 0; f < 3; f++) begin
      push_frame(nums[f], 1'b1, 6'd0, 6'd0);
      for (int c = 0; c < 24; c++) begin
        @(posedge clk); #1;
        got = observe();
        e = exp_q.pop_front();
        n_checks++;
        if (got !== e) begin
          n_errors++;
          $display("FAIL leading_zeros num=%h cyc %0d: got fs=%b idx=%0d sel=%b data=%h dp=%b, expected fs=%b idx=%0d sel=%b data=%h dp=%b",
                   nums[f], c, got.fs, got.idx, got.sel, got.data, got.dp, e.fs, e.idx, e.sel, e.data, e.dp);
        end
      end
    end
  endtask

  task automatic test_coherence_masks();
    exp_t        got, e;
    logic [23:0] nums [4];
    logic [5:0]  bms  [4];
    logic [5:0]  dms  [4];
    nums = '{24'h111111, 24'h999999, 24'h123456, 24'h123456};
    bms  = '{6'b000000, 6'b000000, 6'b000100, 6'b000100};
    dms  = '{6'b000000, 6'b000000, 6'b001000, 6'b001100};
    for (int f = 0; f < 4; f++) begin
      push_frame(nums[f], 1'b0, bms[f], dms[f]);
      for (int c = 0; c < 24; c++) begin
        @(posedge clk); #1;
        got = observe();
        e = exp_q.pop_front();
        n_checks++;
        if (got !== e) begin
          n_errors++;
          $display("FAIL coherence_masks frame %0d cyc %0d: got fs=%b idx=%0d sel=%b data=%h dp=%b, expected fs=%b idx=%0d sel=%b data=%h dp=%b",
                   f, c, got.fs, got.idx, got.sel, got.data, got.dp, e.fs, e.idx, e.sel, e.data, e.dp);
        end
        // Mid-frame change during slot 2 must not reach this frame.
        if (f == 0 && c == 9) number_sig = 24'h999999;
      end
    end
  endtask

  // abort_rst=0 drops en, abort_rst=1 asserts rst, in the first SHOW cycle of slot 3.
  task automatic test_abort(input logic abort_rst, input string name);
    exp_t got, e;
    push_frame(24'h654321, 1'b0, 6'd0, 6'b010101);
    for (int c = 0; c < 14; c++) begin
      @(posedge clk); #1;
      got = observe();
      e = exp_q.pop_front();
      n_checks++;
      if (got !== e) begin
        n_errors++;
        $display("FAIL %s pre cyc %0d: got fs=%b idx=%0d sel=%b data=%h dp=%b, expected fs=%b idx=%0d sel=%b data=%h dp=%b",
                 name, c, got.fs, got.idx, got.sel, got.data, got.dp, e.fs, e.idx, e.sel, e.data, e.dp);
      end
    end
    exp_q.delete();
    if (abort_rst) rst = 1'b1;
    else           en  = 1'b0;
    for (int c = 0; c < 2; c++) begin
      @(posedge clk); #1;
      got = observe();
      n_checks++;
      if (got !== '0) begin
        n_errors++;
        $display("FAIL %s idle cyc %0d: got %h, expected 0", name, c, got);
      end
    end
    rst = 1'b0;
    push_frame(24'h654321, 1'b0, 6'd0, 6'b010101);
    for (int c = 0; c < 24; c++) begin
      @(posedge clk); #1;
      got = observe();
      e = exp_q.pop_front();
      n_checks++;
      if (got !== e) begin
        n_errors++;
        $display("FAIL %s restart cyc %0d: got fs=%b idx=%0d sel=%b data=%h dp=%b, expected fs=%b idx=%0d sel=%b data=%h dp=%b",
                 name, c, got.fs, got.idx, got.sel, got.data, got.dp, e.fs, e.idx, e.sel, e.data, e.dp);
      end
    end
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    test_reset();
    test_basic_scan();
    test_leading_zeros();
    test_coherence_masks();
    test_abort(1'b0, "enable_abort");
    test_abort(1'b1, "reset_abort");
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
